// File: rtl/video_timing_out.sv
// Programmable raster timing generator with latency-matched sync/blanking, a per-frame
// colour-bar test pattern and a completed-frame counter, registered onto the VGA pins.
module video_timing_out #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0,
    parameter int unsigned COLOR_W   = 4,
    parameter int unsigned PIPE_LAT  = 2,
    parameter int unsigned CW        = 10
) (
    input  logic               clk_pix,
    input  logic               resetn,
    input  logic               pattern_en,
    input  logic [COLOR_W-1:0] r,
    input  logic [COLOR_W-1:0] g,
    input  logic [COLOR_W-1:0] b,
    output logic [CW-1:0]      x,
    output logic [CW-1:0]      y,
    output logic               frame_start,
    output logic               line_start,
    output logic [15:0]        frame_count,
    output logic [COLOR_W-1:0] vga_r,
    output logic [COLOR_W-1:0] vga_g,
    output logic [COLOR_W-1:0] vga_b,
    output logic               vga_hsync,
    output logic               vga_vsync
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_ACTIVE + H_FRONT;
    localparam int unsigned VS_START = V_ACTIVE + V_FRONT;
    localparam int unsigned BAR_W    = H_ACTIVE / 8;

    localparam logic [CW-1:0] X_LAST    = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] Y_LAST    = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] X_ACT_END = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] Y_ACT_END = CW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] HS_FIRST  = CW'(HS_START);
    localparam logic [CW-1:0] HS_LAST   = CW'(HS_START + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST  = CW'(VS_START);
    localparam logic [CW-1:0] VS_LAST   = CW'(VS_START + V_SYNC - 1);
    localparam logic [CW-1:0] BAR_LAST  = CW'(BAR_W - 1);

    if (H_ACTIVE % 8 != 0 || H_ACTIVE < 8) begin : g_chk_hact
        $error("H_ACTIVE must be a nonzero multiple of 8");
    end
    if (PIPE_LAT > 15) begin : g_chk_lat
        $error("PIPE_LAT must be in 0..15");
    end
    if ((64'd1 << CW) < 64'(H_TOTAL) || (64'd1 << CW) < 64'(V_TOTAL)) begin : g_chk_cw
        $error("CW too small for H_TOTAL/V_TOTAL");
    end

    typedef struct packed {
        logic       hsync;
        logic       vsync;
        logic       active;
        logic       mode;
        logic [2:0] idx;
    } tap_t;

    localparam tap_t TAP_RST = '{hsync: ~HSYNC_POL, vsync: ~VSYNC_POL,
                                 active: 1'b0, mode: 1'b0, idx: 3'd0};

    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic [CW-1:0] bar_pix_q, bar_pix_d;
    logic [2:0]    bar_idx_q, bar_idx_d;
    logic          pattern_q;
    logic          seen_frame_q;
    logic [15:0]   frame_cnt_q;
    tap_t          tap_raw, tap_out;
    logic [COLOR_W-1:0] col_r, col_g, col_b;

    always_comb begin
        x_d = x_q + CW'(1);
        y_d = y_q;
        if (x_q == X_LAST) begin
            x_d = '0;
            y_d = (y_q == Y_LAST) ? '0 : y_q + CW'(1);
        end
    end

    // Bar counter tracks x so the index is available without a divider.
    always_comb begin
        bar_pix_d = bar_pix_q + CW'(1);
        bar_idx_d = bar_idx_q;
        if (x_d == '0) begin
            bar_pix_d = '0;
            bar_idx_d = 3'd0;
        end else if (bar_pix_q == BAR_LAST) begin
            bar_pix_d = '0;
            bar_idx_d = bar_idx_q + 3'd1;
        end
    end

    always_ff @(posedge clk_pix or negedge resetn) begin
        if (!resetn) begin
            x_q          <= '0;
            y_q          <= '0;
            bar_pix_q    <= '0;
            bar_idx_q    <= 3'd0;
            pattern_q    <= 1'b0;
            seen_frame_q <= 1'b0;
            frame_cnt_q  <= 16'd0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            bar_pix_q <= bar_pix_d;
            bar_idx_q <= bar_idx_d;
            if (frame_start) begin
                pattern_q    <= pattern_en;
                seen_frame_q <= 1'b1;
                if (seen_frame_q) frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign frame_start = (x_q == '0) && (y_q == '0);
    assign line_start  = (x_q == '0) && (y_q <= Y_ACT_END);
    assign frame_count = frame_cnt_q;

    // Pixel (0,0) uses the value being latched this clock so the mode flips on a frame edge.
    always_comb begin
        tap_raw        = TAP_RST;
        tap_raw.active = (x_q <= X_ACT_END) && (y_q <= Y_ACT_END);
        tap_raw.hsync  = (x_q >= HS_FIRST && x_q <= HS_LAST) ? HSYNC_POL : ~HSYNC_POL;
        tap_raw.vsync  = (y_q >= VS_FIRST && y_q <= VS_LAST) ? VSYNC_POL : ~VSYNC_POL;
        tap_raw.mode   = frame_start ? pattern_en : pattern_q;
        tap_raw.idx    = bar_idx_q;
    end

    if (PIPE_LAT == 0) begin : g_no_dly
        assign tap_out = tap_raw;
    end else begin : g_dly
        tap_t dly_q [PIPE_LAT];

        always_ff @(posedge clk_pix or negedge resetn) begin
            if (!resetn) begin
                for (int i = 0; i < int'(PIPE_LAT); i++) dly_q[i] <= TAP_RST;
            end else begin
                dly_q[0] <= tap_raw;
                for (int i = 1; i < int'(PIPE_LAT); i++) dly_q[i] <= dly_q[i-1];
            end
        end

        assign tap_out = dly_q[PIPE_LAT-1];
    end

    always_comb begin
        col_r = '0;
        col_g = '0;
        col_b = '0;
        if (tap_out.active) begin
            if (tap_out.mode) begin
                col_r = {COLOR_W{tap_out.idx[2]}};
                col_g = {COLOR_W{tap_out.idx[1]}};
                col_b = {COLOR_W{tap_out.idx[0]}};
            end else begin
                col_r = r;
                col_g = g;
                col_b = b;
            end
        end
    end

    always_ff @(posedge clk_pix or negedge resetn) begin
        if (!resetn) begin
            vga_r     <= '0;
            vga_g     <= '0;
            vga_b     <= '0;
            vga_hsync <= ~HSYNC_POL;
            vga_vsync <= ~VSYNC_POL;
        end else begin
            vga_r     <= col_r;
            vga_g     <= col_g;
            vga_b     <= col_b;
            vga_hsync <= tap_out.hsync;
            vga_vsync <= tap_out.vsync;
        end
    end

endmodule
